fader_coef_sched: RTL and testbench
===================================

Name: fader_coef_sched

Overview:
- Double-buffered coefficient bank and swap scheduler for the fader's 32-tap complex convolver.
- Host software writes a shadow bank tap by tap, then commits. The block swaps shadow and active banks on the next sample strobe, so every convolver output uses a single consistent tap set.
- Drives the convolver wrapper's packed coef_real/coef_imag arrays directly.
- Provides shadow clear, an arm timeout and a swap counter for the register file.

Parameters:
- NTAPS, 32, number of complex taps per bank (1..32); must match the convolver.
- CW, 18, coefficient width in bits (signed two's complement, real and imag each).
- TIMEOUT, 65535, clock cycles ARMED may wait for sample_tick before abandoning the commit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle strobe marking the sample boundary at the convolver input
- wr_en  in  1  write one shadow tap
- wr_addr  in  5  tap index
- wr_real  in  CW  real part
- wr_imag  in  CW  imag part
- clear_req  in  1  pulse: zero the shadow bank
- commit  in  1  pulse: arm a bank swap
- coef_real  out  [31:0][CW-1:0]  active real taps; entries >= NTAPS tied to 0
- coef_imag  out  [31:0][CW-1:0]  active imag taps; entries >= NTAPS tied to 0
- busy  out  1  high in CLEAR or ARMED
- wr_rejected  out  1  one-cycle pulse: write dropped
- swap_done  out  1  one-cycle pulse: swap happened
- arm_timeout  out  1  sticky: ARMED expired; cleared by next commit or reset
- active_sel  out  1  which bank is active (0 = A, 1 = B)
- swap_count  out  16  swaps since reset; wraps 0xFFFF -> 0

Behaviour:
- Reset: both banks zeroed, active_sel=0, state IDLE, all outputs 0, counters 0. Reset mid-CLEAR or mid-ARMED aborts with no swap.
- Storage: banks A and B, NTAPS x 2 x CW registers each. Shadow = !active_sel. Outputs are registered from the active bank, so changes appear 1 cycle after active_sel toggles.
- States:
  - IDLE, accepts wr_en, clear_req and commit.
  - CLEAR, zeroes shadow[idx] one tap per cycle, idx 0..NTAPS-1 (NTAPS cycles), then returns to IDLE.
  - ARMED, waits for sample_tick.
- IDLE priority when several requests arrive together: clear_req > commit. wr_en in the same cycle is still applied to the shadow bank before the state changes.
- wr_en in IDLE with wr_addr < NTAPS: shadow[wr_addr] updated next cycle.
- wr_en with wr_addr >= NTAPS, or wr_en in CLEAR or ARMED: write dropped; wr_rejected pulses the next cycle.
- commit in CLEAR or ARMED: ignored. clear_req in CLEAR or ARMED: ignored.
- ARMED transitions:
  - Cycle of arming: sample_tick in that same cycle does not trigger a swap; the swap waits for the next tick.
  - sample_tick: active_sel toggles, swap_done pulses, swap_count increments, state returns to IDLE. coef_* change on the following cycle, i.e. 2 cycles after the tick.
  - TIMEOUT cycles with no tick: no swap, arm_timeout set, state returns to IDLE.
- After a swap the shadow bank holds the previously active taps. Software must rewrite or clear it before the next commit.

Optional Feature:
- Macro FADER_COEF_READBACK_EN.
- When defined, adds ports: rd_addr in 5, rd_bank in 1 (0 = shadow, 1 = active), rd_real out CW, rd_imag out CW.
  - Readback is registered with 1-cycle latency.
  - rd_addr >= NTAPS returns 0.
  - Reads are legal in any state.
- When undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Reset, then write tap 0 = (0x00100, 0x3FF00) and commit; tick 5 cycles later -> swap_done 1 cycle after the tick, coef_real[0]=0x00100 and coef_imag[0]=0x3FF00 2 cycles after the tick, active_sel=1, swap_count=1.
- commit and sample_tick in the same cycle, next tick 10 cycles later -> no swap on the first tick; swap_done follows the second tick.
- While ARMED, write tap 3, issue a second commit and a clear_req -> wr_rejected pulses, shadow tap 3 unchanged, commit and clear_req have no effect, busy stays high.
- With TIMEOUT=100, commit with no tick -> after 100 cycles arm_timeout=1, state IDLE, active_sel unchanged; next commit clears arm_timeout.
- Write all 32 taps, clear_req -> busy high for 32 cycles, shadow all zero; active bank and coef_* unchanged throughout.
- Assert reset in the middle of CLEAR -> next cycle all coef_*=0, busy=0, swap_count=0; wr_en with wr_addr=31 when NTAPS=16 -> wr_rejected pulses.

Source files
------------

// File: rtl/fader_coef_sched_if.sv
// Signal bundle between the host/convolver side and fader_coef_sched.
// Defining FADER_COEF_READBACK_EN adds the registered tap readback signals.
interface fader_coef_sched_if #(
   parameter int CW = 18
);
   logic                 sample_tick;
   logic                 wr_en;
   logic [4:0]           wr_addr;
   logic [CW-1:0]        wr_real;
   logic [CW-1:0]        wr_imag;
   logic                 clear_req;
   logic                 commit;
   logic [31:0][CW-1:0]  coef_real;
   logic [31:0][CW-1:0]  coef_imag;
   logic                 busy;
   logic                 wr_rejected;
   logic                 swap_done;
   logic                 arm_timeout;
   logic                 active_sel;
   logic [15:0]          swap_count;
`ifdef FADER_COEF_READBACK_EN
   logic [4:0]           rd_addr;
   logic                 rd_bank;
   logic [CW-1:0]        rd_real;
   logic [CW-1:0]        rd_imag;
`endif

   modport master (
`ifdef FADER_COEF_READBACK_EN
      output rd_addr, rd_bank,
      input  rd_real, rd_imag,
`endif
      output sample_tick, wr_en, wr_addr, wr_real, wr_imag, clear_req, commit,
      input  coef_real, coef_imag, busy, wr_rejected, swap_done, arm_timeout,
      input  active_sel, swap_count
   );

   modport slave (
`ifdef FADER_COEF_READBACK_EN
      input  rd_addr, rd_bank,
      output rd_real, rd_imag,
`endif
      input  sample_tick, wr_en, wr_addr, wr_real, wr_imag, clear_req, commit,
      output coef_real, coef_imag, busy, wr_rejected, swap_done, arm_timeout,
      output active_sel, swap_count
   );
endinterface

// File: rtl/fader_coef_sched.sv
// Double-buffered 32-tap complex coefficient bank with sample-aligned swap scheduling.
// Optional registered tap readback is enabled by defining FADER_COEF_READBACK_EN.
module fader_coef_sched #(
   parameter int NTAPS   = 32,
   parameter int CW      = 18,
   parameter int TIMEOUT = 65535
) (
   input logic               clk,
   input logic               reset,
   fader_coef_sched_if.slave bus
);

   localparam int         TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [5:0] NTAPS6   = 6'(NTAPS);
   localparam logic [4:0] LAST_IDX = 5'(NTAPS - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      ARMED
   } state_t;

   state_t             state_q, state_d;
   logic [4:0]         clrIdx_q, clrIdx_d;
   logic [TW-1:0]      tmoCnt_q, tmoCnt_d;
   logic               activeSel_q, activeSel_d;
   logic [15:0]        swapCount_q, swapCount_d;
   logic               armTimeout_q, armTimeout_d;
   logic               swapDone_q, swapDone_d;
   logic               wrRejected_q, wrRejected_d;

   logic [CW-1:0]      bankReal_q [2][32];
   logic [CW-1:0]      bankImag_q [2][32];
   logic [31:0][CW-1:0] coefReal_q;
   logic [31:0][CW-1:0] coefImag_q;

   logic               tapWrEn;
   logic [4:0]         tapWrIdx;
   logic [CW-1:0]      tapWrReal;
   logic [CW-1:0]      tapWrImag;
   logic               addrInRange;

   assign addrInRange = ({1'b0, bus.wr_addr} < NTAPS6);

   // Next-state logic; the shadow write port is shared by host writes and clearing.
   always_comb begin
      state_d      = state_q;
      clrIdx_d     = clrIdx_q;
      tmoCnt_d     = tmoCnt_q;
      activeSel_d  = activeSel_q;
      swapCount_d  = swapCount_q;
      armTimeout_d = armTimeout_q;
      swapDone_d   = 1'b0;
      wrRejected_d = 1'b0;
      tapWrEn      = 1'b0;
      tapWrIdx     = bus.wr_addr;
      tapWrReal    = bus.wr_real;
      tapWrImag    = bus.wr_imag;

      unique case (state_q)
         IDLE: begin
            if (bus.wr_en) begin
               if (addrInRange) begin
                  tapWrEn = 1'b1;
               end else begin
                  wrRejected_d = 1'b1;
               end
            end
            if (bus.clear_req) begin
               state_d  = CLEAR;
               clrIdx_d = '0;
            end else if (bus.commit) begin
               state_d      = ARMED;
               tmoCnt_d     = '0;
               armTimeout_d = 1'b0;
            end
         end

         CLEAR: begin
            wrRejected_d = bus.wr_en;
            tapWrEn      = 1'b1;
            tapWrIdx     = clrIdx_q;
            tapWrReal    = '0;
            tapWrImag    = '0;
            if (clrIdx_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               clrIdx_d = clrIdx_q + 5'd1;
            end
         end

         ARMED: begin
            // A tick on the arming cycle itself is seen in IDLE and never reaches here.
            wrRejected_d = bus.wr_en;
            if (bus.sample_tick) begin
               activeSel_d = ~activeSel_q;
               swapDone_d  = 1'b1;
               swapCount_d = swapCount_q + 16'd1;
               state_d     = IDLE;
            end else if (tmoCnt_q == TMO_LAST) begin
               armTimeout_d = 1'b1;
               state_d      = IDLE;
            end else begin
               tmoCnt_d = tmoCnt_q + TW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         clrIdx_q     <= '0;
         tmoCnt_q     <= '0;
         activeSel_q  <= 1'b0;
         swapCount_q  <= '0;
         armTimeout_q <= 1'b0;
         swapDone_q   <= 1'b0;
         wrRejected_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clrIdx_q     <= clrIdx_d;
         tmoCnt_q     <= tmoCnt_d;
         activeSel_q  <= activeSel_d;
         swapCount_q  <= swapCount_d;
         armTimeout_q <= armTimeout_d;
         swapDone_q   <= swapDone_d;
         wrRejected_q <= wrRejected_d;
      end
   end

   // Both banks; only the shadow bank (the one not selected) is ever written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int t = 0; t < 32; t++) begin
               bankReal_q[b][t] <= '0;
               bankImag_q[b][t] <= '0;
            end
         end
      end else if (tapWrEn) begin
         bankReal_q[~activeSel_q][tapWrIdx] <= tapWrReal;
         bankImag_q[~activeSel_q][tapWrIdx] <= tapWrImag;
      end
   end

   // Registered coefficient outputs follow the active bank one cycle behind the select.
   always_ff @(posedge clk) begin
      for (int t = 0; t < 32; t++) begin
         if (reset || (t >= NTAPS)) begin
            coefReal_q[t] <= '0;
            coefImag_q[t] <= '0;
         end else begin
            coefReal_q[t] <= bankReal_q[activeSel_q][t];
            coefImag_q[t] <= bankImag_q[activeSel_q][t];
         end
      end
   end

`ifdef FADER_COEF_READBACK_EN
   logic [CW-1:0] rdReal_q;
   logic [CW-1:0] rdImag_q;
   logic          rdBankIdx;

   assign rdBankIdx = bus.rd_bank ? activeSel_q : ~activeSel_q;

   // Readback path; out-of-range taps read as zero.
   always_ff @(posedge clk) begin
      if (reset || ({1'b0, bus.rd_addr} >= NTAPS6)) begin
         rdReal_q <= '0;
         rdImag_q <= '0;
      end else begin
         rdReal_q <= bankReal_q[rdBankIdx][bus.rd_addr];
         rdImag_q <= bankImag_q[rdBankIdx][bus.rd_addr];
      end
   end

   assign bus.rd_real = rdReal_q;
   assign bus.rd_imag = rdImag_q;
`endif

   assign bus.coef_real   = coefReal_q;
   assign bus.coef_imag   = coefImag_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.wr_rejected = wrRejected_q;
   assign bus.swap_done   = swapDone_q;
   assign bus.arm_timeout = armTimeout_q;
   assign bus.active_sel  = activeSel_q;
   assign bus.swap_count  = swapCount_q;

endmodule

// File: tb/tb_fader_coef_sched.sv
// Self-checking bench for fader_coef_sched: directed sequence with random tap data
// compared against a two-bank transaction-level model.
module tb_fader_coef_sched;

   localparam int CW  = 18;
   localparam int TMO = 100;
   localparam int VW  = 32 * CW;

   logic clk = 1'b0;
   logic reset;
   int   testsRun    = 0;
   int   testsFailed = 0;

   always #5 clk = ~clk;

   fader_coef_sched_if #(.CW(CW)) bus ();
   fader_coef_sched_if #(.CW(CW)) bus16 ();

   fader_coef_sched #(.NTAPS(32), .CW(CW), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   fader_coef_sched #(.NTAPS(16), .CW(CW), .TIMEOUT(TMO)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   // Model: two banks of taps, which one is active, and swaps so far.
   logic [CW-1:0] mReal [2][32];
   logic [CW-1:0] mImag [2][32];
   int            mActive;
   int            mSwaps;

   function automatic logic [VW-1:0] packActive(input bit isImag);
      logic [VW-1:0] v;
      v = '0;
      for (int t = 0; t < 32; t++) begin
         v[t*CW +: CW] = isImag ? mImag[mActive][t] : mReal[mActive][t];
      end
      return v;
   endfunction

   function automatic void modelReset();
      for (int b = 0; b < 2; b++) begin
         for (int t = 0; t < 32; t++) begin
            mReal[b][t] = '0;
            mImag[b][t] = '0;
         end
      end
      mActive = 0;
      mSwaps  = 0;
   endfunction

   task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                              input logic [VW-1:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] addr,
                                input logic [CW-1:0] re, input logic [CW-1:0] im);
      bus.wr_en   = we;
      bus.wr_addr = addr;
      bus.wr_real = re;
      bus.wr_imag = im;
   endtask

   task automatic writeTap(input logic [4:0] addr, input logic [CW-1:0] re,
                           input logic [CW-1:0] im);
      applyStimulus(1'b1, addr, re, im);
      cycle();
      applyStimulus(1'b0, 5'd0, '0, '0);
      mReal[1 - mActive][addr] = re;
      mImag[1 - mActive][addr] = im;
      checkOutput("wr_accept", bus.wr_rejected, 0);
   endtask

   task automatic armCommit();
      bus.commit = 1'b1;
      cycle();
      bus.commit = 1'b0;
      checkOutput("armed_busy", bus.busy, 1);
   endtask

   task automatic finishSwap();
      bus.sample_tick = 1'b1;
      cycle();
      bus.sample_tick = 1'b0;
      checkOutput("swap_done_pulse", bus.swap_done, 1);
      checkOutput("coef_real_lag", bus.coef_real, packActive(1'b0));
      mActive = 1 - mActive;
      mSwaps++;
      checkOutput("active_sel", bus.active_sel, mActive);
      checkOutput("swap_count", bus.swap_count, 16'(mSwaps));
      checkOutput("busy_after_swap", bus.busy, 0);
      cycle();
      checkOutput("swap_done_single", bus.swap_done, 0);
      checkOutput("coef_real", bus.coef_real, packActive(1'b0));
      checkOutput("coef_imag", bus.coef_imag, packActive(1'b1));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int busyCycles;
      int coefDrift;
      logic rejSeen;
      logic [CW-1:0] tap3Real;
      logic [VW-1:0] exp16;

      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, '0, '0);
      bus.sample_tick = 1'b0;
      bus.clear_req   = 1'b0;
      bus.commit      = 1'b0;
      bus16.sample_tick = 1'b0;
      bus16.wr_en       = 1'b0;
      bus16.wr_addr     = '0;
      bus16.wr_real     = '0;
      bus16.wr_imag     = '0;
      bus16.clear_req   = 1'b0;
      bus16.commit      = 1'b0;
      modelReset();
      repeat (3) cycle();
      reset = 1'b0;
      cycle();

      $display("[TB] reset state");
      checkOutput("rst_coef_real", bus.coef_real, '0);
      checkOutput("rst_coef_imag", bus.coef_imag, '0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_active_sel", bus.active_sel, 0);
      checkOutput("rst_swap_count", bus.swap_count, 0);
      checkOutput("rst_arm_timeout", bus.arm_timeout, 0);
      checkOutput("rst_swap_done", bus.swap_done, 0);

      $display("[TB] single tap commit, tick 5 cycles after commit");
      writeTap(5'd0, 18'h00100, 18'h3FF00);
      armCommit();
      repeat (4) cycle();
      finishSwap();
      checkOutput("tap0_real", bus.coef_real[0], 18'h00100);
      checkOutput("tap0_imag", bus.coef_imag[0], 18'h3FF00);

      $display("[TB] random writes, commit coincident with tick");
      for (int i = 0; i < 20; i++) begin
         writeTap(5'($urandom_range(0, 31)), CW'($urandom), CW'($urandom));
      end
      bus.commit      = 1'b1;
      bus.sample_tick = 1'b1;
      cycle();
      bus.commit      = 1'b0;
      bus.sample_tick = 1'b0;
      checkOutput("same_cycle_no_swap", bus.swap_done, 0);
      checkOutput("same_cycle_busy", bus.busy, 1);
      repeat (9) cycle();
      checkOutput("same_cycle_count_held", bus.swap_count, 16'(mSwaps));
      checkOutput("same_cycle_sel_held", bus.active_sel, mActive);
      finishSwap();

      $display("[TB] requests while armed");
      for (int i = 0; i < 8; i++) begin
         writeTap(5'($urandom_range(0, 31)), CW'($urandom), CW'($urandom));
      end
      tap3Real = CW'($urandom);
      writeTap(5'd3, tap3Real, CW'($urandom));
      armCommit();
      applyStimulus(1'b1, 5'd3, ~tap3Real, CW'($urandom));
      bus.commit    = 1'b1;
      bus.clear_req = 1'b1;
      cycle();
      applyStimulus(1'b0, 5'd0, '0, '0);
      bus.commit    = 1'b0;
      bus.clear_req = 1'b0;
      checkOutput("armed_wr_rejected", bus.wr_rejected, 1);
      checkOutput("armed_busy_hold", bus.busy, 1);
      cycle();
      checkOutput("armed_rej_single", bus.wr_rejected, 0);
      repeat (3) cycle();
      checkOutput("armed_still_busy", bus.busy, 1);
      finishSwap();
      checkOutput("armed_tap3_kept", bus.coef_real[3], tap3Real);

      $display("[TB] arm timeout");
      armCommit();
      repeat (TMO - 1) cycle();
      checkOutput("tmo_not_yet", bus.arm_timeout, 0);
      checkOutput("tmo_busy_last", bus.busy, 1);
      cycle();
      checkOutput("tmo_set", bus.arm_timeout, 1);
      checkOutput("tmo_idle", bus.busy, 0);
      checkOutput("tmo_sel_held", bus.active_sel, mActive);
      checkOutput("tmo_count_held", bus.swap_count, 16'(mSwaps));
      repeat (3) cycle();
      checkOutput("tmo_sticky", bus.arm_timeout, 1);
      armCommit();
      checkOutput("tmo_cleared", bus.arm_timeout, 0);
      repeat (2) cycle();
      finishSwap();

      $display("[TB] shadow clear");
      for (int t = 0; t < 32; t++) begin
         writeTap(5'(t), CW'($urandom) | 18'h1, CW'($urandom));
      end
      applyStimulus(1'b1, 5'd5, 18'h0ABCD, 18'h0DCBA);
      bus.clear_req = 1'b1;
      cycle();
      applyStimulus(1'b0, 5'd0, '0, '0);
      bus.clear_req = 1'b0;
      checkOutput("clear_wr_same_cycle", bus.wr_rejected, 0);
      busyCycles = 0;
      coefDrift  = 0;
      rejSeen    = 1'b0;
      for (int k = 0; k < 40 && bus.busy; k++) begin
         busyCycles++;
         if (bus.coef_real !== packActive(1'b0) || bus.coef_imag !== packActive(1'b1)) begin
            coefDrift++;
         end
         applyStimulus(k == 10, 5'd7, 18'h15555, 18'h0AAAA);
         cycle();
         if (k == 10) rejSeen = bus.wr_rejected;
      end
      applyStimulus(1'b0, 5'd0, '0, '0);
      for (int t = 0; t < 32; t++) begin
         mReal[1 - mActive][t] = '0;
         mImag[1 - mActive][t] = '0;
      end
      checkOutput("clear_busy_cycles", busyCycles, 32);
      checkOutput("clear_coef_stable", coefDrift, 0);
      checkOutput("clear_wr_rejected", rejSeen, 1);
      armCommit();
      repeat (3) cycle();
      finishSwap();

      $display("[TB] reset during clear");
      for (int i = 0; i < 4; i++) begin
         writeTap(5'($urandom_range(0, 31)), CW'($urandom) | 18'h1, CW'($urandom));
      end
      armCommit();
      finishSwap();
      bus.clear_req = 1'b1;
      cycle();
      bus.clear_req = 1'b0;
      repeat (5) cycle();
      checkOutput("mid_clear_busy", bus.busy, 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      modelReset();
      checkOutput("rst2_coef_real", bus.coef_real, '0);
      checkOutput("rst2_coef_imag", bus.coef_imag, '0);
      checkOutput("rst2_busy", bus.busy, 0);
      checkOutput("rst2_swap_count", bus.swap_count, 0);
      checkOutput("rst2_active_sel", bus.active_sel, 0);

      $display("[TB] NTAPS=16 instance boundaries");
      bus16.wr_en   = 1'b1;
      bus16.wr_addr = 5'd31;
      bus16.wr_real = 18'h12345;
      bus16.wr_imag = 18'h23456;
      cycle();
      checkOutput("n16_addr31_rejected", bus16.wr_rejected, 1);
      bus16.wr_addr = 5'd16;
      cycle();
      checkOutput("n16_addr16_rejected", bus16.wr_rejected, 1);
      bus16.wr_addr = 5'd15;
      bus16.wr_real = 18'h0F0F0;
      bus16.wr_imag = 18'h30303;
      cycle();
      checkOutput("n16_addr15_accepted", bus16.wr_rejected, 0);
      bus16.wr_en  = 1'b0;
      bus16.commit = 1'b1;
      cycle();
      bus16.commit      = 1'b0;
      bus16.sample_tick = 1'b1;
      cycle();
      bus16.sample_tick = 1'b0;
      checkOutput("n16_swap_done", bus16.swap_done, 1);
      cycle();
      exp16 = '0;
      exp16[15*CW +: CW] = 18'h0F0F0;
      checkOutput("n16_coef_real", bus16.coef_real, exp16);
      exp16 = '0;
      exp16[15*CW +: CW] = 18'h30303;
      checkOutput("n16_coef_imag", bus16.coef_imag, exp16);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
